// File: rtl/fc_rd_ctrl.sv
// Purpose: fetches the data and weight matrices, then the bias vector, from a word memory for one FC layer.
// Latency: N_DW+1 cycles from start to data/weight valid; bias_size+1 cycles from bias_rq to bias valid.
// Backpressure: holds each set of matrices valid until the FC block answers with bias_rq or result_valid.
// Ports: clk/rst_n; start; memory read port mem_rd/mem_addr/mem_rdata (1-cycle read latency);
//        data/weight/bias matrices with data_en/weight_en/bias_en; bias_rq/result_valid from the FC block;
//        busy level and done pulse.
module fc_rd_ctrl #(
    parameter int batch_size   = 1,
    parameter int feature_size = 3,
    parameter int bias_size    = 2,
    parameter int ADDR_W       = 16,
    parameter int DATA_BASE    = 0,
    parameter int WEIGHT_BASE  = 16,
    parameter int BIAS_BASE    = 32
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            start,
    output logic                                            mem_rd,
    output logic [ADDR_W-1:0]                               mem_addr,
    input  logic [31:0]                                     mem_rdata,
    output logic [batch_size-1:0][feature_size-1:0][31:0]   data,
    output logic [feature_size-1:0][bias_size-1:0][31:0]    weight,
    output logic [bias_size-1:0][31:0]                      bias,
    output logic                                            data_en,
    output logic                                            weight_en,
    output logic                                            bias_en,
    input  logic                                            bias_rq,
    input  logic                                            result_valid,
    output logic                                            busy,
    output logic                                            done
);

    localparam int N_D   = batch_size * feature_size;
    localparam int N_W   = feature_size * bias_size;
    localparam int N_DW  = N_D + N_W;
    localparam int N_MAX = (N_DW > bias_size) ? N_DW : bias_size;
    localparam int CNT_W = $clog2(N_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_DW, PRESENT_DW, LOAD_B, PRESENT_B, FINISH
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]         addr_q;
    logic                      rd;
    logic [ADDR_W-1:0]         rd_addr;

    // Capture pipeline: remembers which element the word arriving next cycle belongs to.
    logic                      cap_vld_q;
    logic                      cap_bias_q;
    logic [CNT_W-1:0]          cap_idx_q;

    logic [N_D-1:0][31:0]        data_q;
    logic [N_W-1:0][31:0]        weight_q;
    logic [bias_size-1:0][31:0]  bias_q;

    // Next-state and outputs. The load states run one extra cycle past the last
    // read so the final word is captured before the matrices are presented.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd        = 1'b0;
        rd_addr   = addr_q;
        data_en   = 1'b0;
        weight_en = 1'b0;
        bias_en   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_DW;
                    cnt_d   = '0;
                end
            end
            LOAD_DW: begin
                if (cnt_q < CNT_W'(N_DW)) begin
                    rd = 1'b1;
                    // Both matrices are row-major and contiguous, so the flat
                    // element index is also the offset from each base.
                    if (cnt_q < CNT_W'(N_D)) begin
                        rd_addr = ADDR_W'(DATA_BASE) + ADDR_W'(cnt_q);
                    end else begin
                        rd_addr = ADDR_W'(WEIGHT_BASE) + ADDR_W'(cnt_q) - ADDR_W'(N_D);
                    end
                end
                if (cnt_q == CNT_W'(N_DW)) begin
                    state_d = PRESENT_DW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESENT_DW: begin
                data_en   = 1'b1;
                weight_en = 1'b1;
                if (bias_rq) begin
                    state_d = LOAD_B;
                    cnt_d   = '0;
                end
            end
            LOAD_B: begin
                if (cnt_q < CNT_W'(bias_size)) begin
                    rd      = 1'b1;
                    rd_addr = ADDR_W'(BIAS_BASE) + ADDR_W'(cnt_q);
                end
                if (cnt_q == CNT_W'(bias_size)) begin
                    state_d = PRESENT_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESENT_B: begin
                bias_en = 1'b1;
                if (result_valid) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd   = rd;
    assign mem_addr = rd_addr;
    assign busy     = (state_q != IDLE);
    assign data     = data_q;
    assign weight   = weight_q;
    assign bias     = bias_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_bias_q <= 1'b0;
            cap_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (rd) begin
                addr_q <= rd_addr;
            end
            // Cleared by reset so a word still returning after release is dropped.
            cap_vld_q  <= rd;
            cap_bias_q <= (state_q == LOAD_B);
            cap_idx_q  <= cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            weight_q <= '0;
            bias_q   <= '0;
        end else if (cap_vld_q) begin
            if (cap_bias_q) begin
                for (int k = 0; k < bias_size; k++) begin
                    if (cap_idx_q == CNT_W'(k)) bias_q[k] <= mem_rdata;
                end
            end else begin
                for (int k = 0; k < N_D; k++) begin
                    if (cap_idx_q == CNT_W'(k)) data_q[k] <= mem_rdata;
                end
                for (int k = 0; k < N_W; k++) begin
                    if (cap_idx_q == CNT_W'(N_D + k)) weight_q[k] <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: doc/fc_rd_ctrl.md
FC_RD_CTRL -- requirements
Module: fc_rd_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): batch_size, 1, rows of the data matrix; feature_size, 3, data columns and weight rows; bias_size, 2, weight columns and bias length; ADDR_W, 16, memory address width; DATA_BASE, 0, word address of data[0][0]; WEIGHT_BASE, 16, word address of weight[0][0]; BIAS_BASE, 32, word address of bias[0].
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin one layer transaction.
- mem_rd, out, 1, read strobe.
- mem_addr, out, ADDR_W, word address.
- mem_rdata, in, 32, read data, fixed 1-cycle latency.
- data, out, [batch_size][feature_size][32], data matrix to the fully-connected block.
- weight, out, [feature_size][bias_size][32], weight matrix.
- bias, out, [bias_size][32], bias vector.
- data_en, out, 1, data valid.
- weight_en, out, 1, weight valid.
- bias_en, out, 1, bias valid.
- bias_rq, in, 1, bias request from the fully-connected block.
- result_valid, in, 1, layer result accepted by the fully-connected block.
- busy, out, 1, transaction in progress.
- done, out, 1, one-cycle pulse at transaction end.

Function
REQ-003 The block SHALL implement states IDLE, LOAD_DW, PRESENT_DW, LOAD_B, PRESENT_B and FINISH.
REQ-004 IDLE SHALL go to LOAD_DW on start==1; start SHALL be ignored in every other state.
REQ-005 LOAD_DW SHALL issue exactly N_DW = batch_size*feature_size + feature_size*bias_size reads, one per cycle with mem_rd=1, in this order:
- data row-major: data[i][j] at DATA_BASE + i*feature_size + j;
- then weight row-major: weight[r][c] at WEIGHT_BASE + r*bias_size + c.
REQ-006 The word read in cycle t SHALL be captured from mem_rdata at t+1 into its matrix element. LOAD_DW SHALL last N_DW+1 cycles, then go to PRESENT_DW.
REQ-007 PRESENT_DW SHALL hold data_en=1 and weight_en=1 (both asserted in the same cycle) until bias_rq==1 is sampled. It SHALL then go to LOAD_B, and both enables SHALL be 0 from the next cycle.
REQ-008 bias_rq SHALL be ignored in every state except PRESENT_DW.
REQ-009 LOAD_B SHALL issue bias_size reads from BIAS_BASE + k, k=0..bias_size-1, with the same capture timing as REQ-006. It SHALL last bias_size+1 cycles, then go to PRESENT_B.
REQ-010 PRESENT_B SHALL hold bias_en=1 until result_valid==1 is sampled, then go to FINISH with bias_en=0 from the next cycle.
REQ-011 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 mem_rd SHALL be 0 outside read-issue cycles. mem_addr SHALL hold its last value when mem_rd=0.
REQ-014 The data, weight and bias registers SHALL change only on capture cycles and SHALL hold their values between transactions.
REQ-015 result_valid sampled in any state other than PRESENT_B SHALL be ignored.
REQ-016 If start and result_valid arrive in the same cycle in PRESENT_B, start SHALL be ignored; a new transaction requires start in IDLE.

Reset
REQ-017 While rst_n==0 (asynchronous, any state, including mid-load), the block SHALL set:
- state to IDLE;
- mem_rd, data_en, weight_en, bias_en, busy and done to 0;
- mem_addr to 0;
- all data, weight and bias registers to 0.
REQ-018 In-flight reads SHALL be discarded on reset. Read data returning after reset release SHALL NOT be captured.

Verification (batch_size=1, feature_size=3, bias_size=2; mem[a]=a+1)
REQ-019 Basic load:
- Stimulus: start pulse.
- Response: 9 consecutive mem_rd cycles at addresses 0,1,2,16..21; the cycle after the last capture, data=[1,2,3], weight=[[17,18],[19,20],[21,22]], data_en=weight_en=1.
REQ-020 Bias handshake:
- Stimulus: bias_rq pulse 5 cycles into PRESENT_DW.
- Response: enables fall the next cycle; reads at 32,33; bias=[33,34] with bias_en=1; bias_en holds until result_valid; done pulses once, then busy=0.
REQ-021 Ignored inputs:
- Stimulus: bias_rq and start asserted during LOAD_DW; result_valid asserted during PRESENT_DW.
- Response: no state change, read sequence unchanged.
REQ-022 Reset mid-operation:
- Stimulus: rst_n low at the 4th read of LOAD_DW.
- Response: all outputs 0 immediately; after release, IDLE with busy=0; a new start repeats REQ-019 exactly.
REQ-023 Back-to-back:
- Stimulus: start the cycle after done.
- Response: second transaction identical to the first.
